// File: rtl/decode.sv
// RV32I decode stage: captures the fetched word on an enabled cycle and holds registered
// decoded fields, immediate, ALU op and class flags until the next capture.
module decode #(
    parameter bit          ZERO_IS_NOP = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enabled,
    input  logic [31:0]      instr_raw,
    input  logic [31:0]      pc,
    output logic             completed,
    output logic [31:0]      pc_d,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [2:0]       funct3,
    output logic [31:0]      imm,
    output logic [3:0]       alu_op,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic             is_load,
    output logic             is_store,
    output logic             is_branch,
    output logic             is_jal,
    output logic             is_jalr,
    output logic             is_lui,
    output logic             is_auipc,
    output logic             is_ecall,
    output logic             is_ebreak,
    output logic             is_mret,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_count
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ALU_W = 4;

    localparam logic [ALU_W-1:0] ALU_ADD   = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB   = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_SLL   = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_SLT   = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_SLTU  = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_XOR   = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SRL   = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SRA   = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_OR    = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_AND   = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_PASSB = ALU_W'(10);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [XLEN-1:0] W_ECALL  = 32'h0000_0073;
    localparam logic [XLEN-1:0] W_EBREAK = 32'h0010_0073;
    localparam logic [XLEN-1:0] W_MRET   = 32'h3020_0073;

    typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;

    state_t state, state_nxt;

    // Decoded values, registered on capture
    logic [XLEN-1:0]  d_imm;
    logic [ALU_W-1:0] d_alu_op;
    logic             d_src_imm, d_we, d_load, d_store, d_branch, d_jal, d_jalr;
    logic             d_lui, d_auipc, d_ecall, d_ebreak, d_mret, d_illegal;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd_f;

    assign opcode = instr_raw[6:0];
    assign f3     = instr_raw[14:12];
    assign f7     = instr_raw[31:25];
    assign rd_f   = instr_raw[11:7];

    // funct3 -> ALU op for the base (funct7 = 0) integer ops
    function automatic logic [ALU_W-1:0] base_op(input logic [2:0] f);
        logic [ALU_W-1:0] op;
        case (f)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        d_imm     = '0;
        d_alu_op  = ALU_ADD;
        d_src_imm = 1'b0;
        d_we      = 1'b0;
        d_load    = 1'b0;
        d_store   = 1'b0;
        d_branch  = 1'b0;
        d_jal     = 1'b0;
        d_jalr    = 1'b0;
        d_lui     = 1'b0;
        d_auipc   = 1'b0;
        d_ecall   = 1'b0;
        d_ebreak  = 1'b0;
        d_mret    = 1'b0;
        d_illegal = 1'b0;
        case (opcode)
            OPC_R: begin
                d_we = 1'b1;
                if (f7 == F7_BASE) begin
                    d_alu_op = base_op(f3);
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    d_alu_op = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    d_alu_op = ALU_SRA;
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OPC_IMM: begin
                d_we      = 1'b1;
                d_src_imm = 1'b1;
                d_imm     = {{20{instr_raw[31]}}, instr_raw[31:20]};
                d_alu_op  = base_op(f3);
                // Shift-immediates carry funct7 in imm[11:5]
                if (f3 == 3'b001 && f7 != F7_BASE) begin
                    d_illegal = 1'b1;
                end else if (f3 == 3'b101) begin
                    if (f7 == F7_ALT) begin
                        d_alu_op = ALU_SRA;
                    end else if (f7 != F7_BASE) begin
                        d_illegal = 1'b1;
                    end
                end
            end
            OPC_LOAD: begin
                d_we      = 1'b1;
                d_load    = 1'b1;
                d_src_imm = 1'b1;
                d_imm     = {{20{instr_raw[31]}}, instr_raw[31:20]};
                d_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                d_store   = 1'b1;
                d_src_imm = 1'b1;
                d_imm     = {{20{instr_raw[31]}}, instr_raw[31:25], instr_raw[11:7]};
                d_illegal = (f3 >= 3'b011);
            end
            OPC_BRANCH: begin
                d_branch  = 1'b1;
                d_alu_op  = ALU_SUB;
                d_imm     = {{19{instr_raw[31]}}, instr_raw[31], instr_raw[7],
                             instr_raw[30:25], instr_raw[11:8], 1'b0};
                d_illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JAL: begin
                d_we  = 1'b1;
                d_jal = 1'b1;
                d_imm = {{11{instr_raw[31]}}, instr_raw[31], instr_raw[19:12],
                         instr_raw[20], instr_raw[30:21], 1'b0};
            end
            OPC_JALR: begin
                d_we      = 1'b1;
                d_jalr    = 1'b1;
                d_src_imm = 1'b1;
                d_imm     = {{20{instr_raw[31]}}, instr_raw[31:20]};
                d_illegal = (f3 != 3'b000);
            end
            OPC_LUI: begin
                d_we      = 1'b1;
                d_lui     = 1'b1;
                d_src_imm = 1'b1;
                d_alu_op  = ALU_PASSB;
                d_imm     = {instr_raw[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                d_we      = 1'b1;
                d_auipc   = 1'b1;
                d_src_imm = 1'b1;
                d_imm     = {instr_raw[31:12], 12'b0};
            end
            OPC_SYSTEM: begin
                d_ecall   = (instr_raw == W_ECALL);
                d_ebreak  = (instr_raw == W_EBREAK);
                d_mret    = (instr_raw == W_MRET);
                d_illegal = !(d_ecall || d_ebreak || d_mret);
            end
            default: begin
                d_illegal = !(ZERO_IS_NOP && instr_raw == '0);
            end
        endcase
        // An illegal word must not write or trigger any memory/control-flow action
        if (d_illegal) begin
            d_we     = 1'b0;
            d_load   = 1'b0;
            d_store  = 1'b0;
            d_branch = 1'b0;
            d_jal    = 1'b0;
            d_jalr   = 1'b0;
        end
        if (rd_f == 5'd0) begin
            d_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // completed is combinational: a re-enable while DONE masks the pulse
    always_comb begin
        state_nxt = state;
        completed = 1'b0;
        if (enabled) begin
            state_nxt = DONE;
        end else if (state == DONE) begin
            state_nxt = IDLE;
            completed = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_d        <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            funct3      <= '0;
            imm         <= '0;
            alu_op      <= '0;
            alu_src_imm <= 1'b0;
            reg_we      <= 1'b0;
            is_load     <= 1'b0;
            is_store    <= 1'b0;
            is_branch   <= 1'b0;
            is_jal      <= 1'b0;
            is_jalr     <= 1'b0;
            is_lui      <= 1'b0;
            is_auipc    <= 1'b0;
            is_ecall    <= 1'b0;
            is_ebreak   <= 1'b0;
            is_mret     <= 1'b0;
            illegal     <= 1'b0;
            dec_count   <= '0;
        end else if (enabled) begin
            pc_d        <= pc;
            rs1         <= instr_raw[19:15];
            rs2         <= instr_raw[24:20];
            rd          <= rd_f;
            funct3      <= f3;
            imm         <= d_imm;
            alu_op      <= d_alu_op;
            alu_src_imm <= d_src_imm;
            reg_we      <= d_we;
            is_load     <= d_load;
            is_store    <= d_store;
            is_branch   <= d_branch;
            is_jal      <= d_jal;
            is_jalr     <= d_jalr;
            is_lui      <= d_lui;
            is_auipc    <= d_auipc;
            is_ecall    <= d_ecall;
            is_ebreak   <= d_ebreak;
            is_mret     <= d_mret;
            illegal     <= d_illegal;
            dec_count   <= dec_count + CNT_W'(1);
        end
    end

endmodule
